// File: rtl/if_stage.sv
// miniLA instruction-fetch stage: PC, synchronous ROM request and IF/ID register.
// A one-entry skid buffer holds the in-flight ROM response across a stall.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0340_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        pipeline_stop,
    input  logic        flush_if_id,
    input  logic [31:0] redirect_pc,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        req_valid_q;
    logic [31:0] req_pc_q;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_valid;

    assign skid_valid = (state == HOLD);

    assign irom_req  = !cpu_rst && (flush_if_id || !pipeline_stop);
    assign irom_addr = flush_if_id ? {redirect_pc[31:2], 2'b00}
                                   : {pc_q[31:2], 2'b00};

    // Priority on each edge: flush, then stop, then advance.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= RUN;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= 32'h0;
            skid_pc     <= 32'h0;
            skid_inst   <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_inst  <= INST_NOP;
        end else if (flush_if_id) begin
            state       <= RUN;
            if_id_valid <= 1'b0;
            if_id_inst  <= INST_NOP;
            req_valid_q <= 1'b1;
            req_pc_q    <= redirect_pc;
            pc_q        <= redirect_pc + 32'd4;
        end else if (pipeline_stop) begin
            if (req_valid_q) begin
                state     <= HOLD;
                skid_pc   <= req_pc_q;
                skid_inst <= irom_rdata;
            end
            req_valid_q <= 1'b0;
        end else begin
            if (skid_valid) begin
                state       <= RUN;
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_pc;
                if_id_pc4   <= skid_pc + 32'd4;
                if_id_inst  <= skid_inst;
            end else if (req_valid_q) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc_q;
                if_id_pc4   <= req_pc_q + 32'd4;
                if_id_inst  <= irom_rdata;
            end else begin
                if_id_valid <= 1'b0;
                if_id_inst  <= INST_NOP;
            end
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
            pc_q        <= pc_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a latency-1 ROM model
// that returns addr | 32'hA000.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0340_0000;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        pipeline_stop;
    logic        flush_if_id;
    logic [31:0] redirect_pc;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic [31:0] irom_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [96:0] obs;
    logic [96:0] exp_v;

    if_stage dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .pipeline_stop(pipeline_stop),
        .flush_if_id  (flush_if_id),
        .redirect_pc  (redirect_pc),
        .irom_req     (irom_req),
        .irom_addr    (irom_addr),
        .irom_rdata   (irom_rdata),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_inst   (if_id_inst)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial irom_rdata = 32'h0;
    always @(posedge cpu_clk)
        if (irom_req) irom_rdata <= irom_addr | 32'h0000_A000;

    assign obs = {if_id_valid, if_id_pc, if_id_pc4, if_id_inst};

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_rst       = 1'b1;
        pipeline_stop = 1'b0;
        flush_if_id   = 1'b0;
        redirect_pc   = 32'h0;
        tick();
        tick();
        cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        cpu_rst       = 1'b1;
        pipeline_stop = 1'b0;
        flush_if_id   = 1'b0;
        redirect_pc   = 32'h0;
        tick();
        exp_v = {1'b0, 32'h0, 32'h0, NOP};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_ifid got=%h exp=%h", obs, exp_v);
        end
        n_checks++;
        if ({irom_req, irom_addr} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_rom got=%b/%h exp=0/0", irom_req, irom_addr);
        end
        cpu_rst = 1'b0;
        #1;
        n_checks++;
        if ({irom_req, irom_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL first_req got=%b/%h exp=1/0", irom_req, irom_addr);
        end
        tick();
        n_checks++;
        if (if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL edge1_bubble got=%b exp=0", if_id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {1'b1, 32'(4 * i), 32'(4 * i + 4), 32'(4 * i) | 32'hA000};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stream%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_stall_1();
        logic [31:0] seq [5] = '{32'h4, 32'h4, 32'h8, 32'hC, 32'h10};
        do_reset();
        tick();
        tick();
        tick();
        pipeline_stop = 1'b1;
        #1;
        n_checks++;
        if (irom_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall1_req got=%b exp=0", irom_req);
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            pipeline_stop = 1'b0;
            exp_v = {1'b1, seq[i], seq[i] + 32'd4, seq[i] | 32'hA000};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall1_seq%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_stall_3();
        logic [31:0] seq [3] = '{32'h8, 32'hC, 32'h10};
        do_reset();
        tick();
        tick();
        tick();
        pipeline_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {1'b1, 32'h4, 32'h8, 32'hA004};
            n_checks++;
            if (obs !== exp_v || irom_addr !== 32'hC) begin
                n_fail++;
                $display("FAIL stall3_hold%0d got=%h/%h exp=%h/0000000c",
                         i, obs, irom_addr, exp_v);
            end
        end
        pipeline_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {1'b1, seq[i], seq[i] + 32'd4, seq[i] | 32'hA000};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall3_seq%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        tick();
        tick();
        tick();
        flush_if_id = 1'b1;
        redirect_pc = 32'h103;
        #1;
        n_checks++;
        if ({irom_req, irom_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL flush_addr_align got=%b/%h exp=1/00000100",
                     irom_req, irom_addr);
        end
        redirect_pc = 32'h100;
        tick();
        flush_if_id = 1'b0;
        exp_v = {1'b0, 32'h4, 32'h8, NOP};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL flush_bubble got=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 32'h100, 32'h104, 32'hA100};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL flush_target got=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 32'h104, 32'h108, 32'hA104};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL flush_next got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_flush_in_hold();
        do_reset();
        tick();
        tick();
        tick();
        pipeline_stop = 1'b1;
        tick();
        flush_if_id = 1'b1;
        redirect_pc = 32'h200;
        #1;
        n_checks++;
        if ({irom_req, irom_addr} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL fh_req got=%b/%h exp=1/00000200",
                     irom_req, irom_addr);
        end
        tick();
        flush_if_id   = 1'b0;
        pipeline_stop = 1'b0;
        exp_v = {1'b0, 32'h4, 32'h8, NOP};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fh_bubble got=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 32'h200, 32'h204, 32'hA200};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fh_target got=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 32'h204, 32'h208, 32'hA204};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fh_next got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        tick();
        tick();
        tick();
        pipeline_stop = 1'b1;
        tick();
        cpu_rst = 1'b1;
        #1;
        exp_v = {1'b0, 32'h0, 32'h0, NOP};
        n_checks++;
        if (obs !== exp_v || irom_req !== 1'b0 || irom_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got=%h/%b/%h exp=%h/0/0",
                     obs, irom_req, irom_addr, exp_v);
        end
        tick();
        pipeline_stop = 1'b0;
        cpu_rst       = 1'b0;
        tick();
        tick();
        exp_v = {1'b1, 32'h0, 32'h4, 32'hA000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL refetch got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        tick();
        tick();
        tick();
        flush_if_id = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        flush_if_id = 1'b0;
        tick();
        exp_v = {1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_a got=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_b got=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 32'h0, 32'h4, 32'hA000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_c got=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_stall_1();
        test_stall_3();
        test_flush();
        test_flush_in_hold();
        test_reset_mid_stall();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the miniLA five-stage pipeline: owns the PC, drives the synchronous instruction ROM, and produces the IF/ID pipeline register consumed by decode and by the hazard detector. It honours `pipeline_stop` (load-use stall) and `flush_if_id` (taken branch or jump resolved in EX). A one-entry skid buffer captures the ROM response that is already in flight when a stall begins, so no instruction is lost or refetched.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `INST_NOP`, 32'h0340_0000, instruction word placed in IF/ID for bubbles (`andi r0,r0,0`)

- `cpu_clk`  in  1  pipeline clock, all state updates on its rising edge
- `cpu_rst`  in  1  asynchronous, active-high reset
- `pipeline_stop`  in  1  hold PC and IF/ID this cycle (from hazard detector)
- `flush_if_id`  in  1  redirect fetch and kill IF/ID this cycle
- `redirect_pc`  in  32  branch/jump target, valid when `flush_if_id`=1
- `irom_req`  out  1  fetch request this cycle
- `irom_addr`  out  32  fetch address, bits [1:0] forced to 0
- `irom_rdata`  in  32  instruction for the request issued in the previous cycle (latency 1)
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_pc`  out  32  PC of the IF/ID instruction
- `if_id_pc4`  out  32  `if_id_pc`+4
- `if_id_inst`  out  32  instruction word

## Operation
- State: `pc_q` (next address to issue), `req_valid_q`/`req_pc_q` (request issued last cycle, response present now), skid `{skid_valid, skid_pc, skid_inst}`, IF/ID register.
- FSM: RUN (`skid_valid`=0) and HOLD (`skid_valid`=1). RUN→HOLD on a stop cycle with `req_valid_q`=1. HOLD→RUN on the first non-stop cycle or on any flush.
- Combinational: `irom_req` = !`cpu_rst` & (`flush_if_id` | !`pipeline_stop`). `irom_addr` = `flush_if_id` ? `redirect_pc` : `pc_q`.
- Priority per edge: flush > stop > advance.
- Flush: IF/ID ← bubble (valid=0, inst=`INST_NOP`, pc/pc4 hold). Skid cleared. `req_valid_q`←1, `req_pc_q`←`redirect_pc`, `pc_q`←`redirect_pc`+4. The response currently on `irom_rdata` is discarded.
- Stop (no flush): IF/ID and `pc_q` hold. If `req_valid_q`, then skid ← {`req_pc_q`, `irom_rdata`} and `skid_valid`←1. `req_valid_q`←0.
- Advance:
  - If `skid_valid`, IF/ID ← skid and skid is cleared.
  - Else if `req_valid_q`, IF/ID ← {`req_pc_q`, `irom_rdata`, valid=1}.
  - Else IF/ID ← bubble.
  - In all three cases, `req_valid_q`←1, `req_pc_q`←`pc_q`, `pc_q`←`pc_q`+4.
- Invariant: `skid_valid` and `req_valid_q` are never both 1.
- Arithmetic: all PC adds are 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - `pc_q`=`RESET_PC`; `req_valid_q`=0; `skid_valid`=0.
  - `if_id_valid`=0, `if_id_inst`=`INST_NOP`, `if_id_pc`=0, `if_id_pc4`=0.
  - `irom_req`=0; `irom_addr`=`RESET_PC` (flush low).
- First cycle after reset release: request `RESET_PC`. IF/ID becomes valid at the second edge after release.
- Fetch-to-IF/ID latency is 2 edges; steady-state throughput is 1 instruction per cycle.
- Stall of N cycles:
  - IF/ID frozen for N edges.
  - The in-flight response is captured in the first stall cycle.
  - On release: skid → IF/ID, then the new request → IF/ID with no bubble.
- Flush: exactly one bubble in IF/ID. The target instruction appears in IF/ID at the second edge after the flush cycle, unless another flush or a stop intervenes.
- Flush and stop in the same cycle: flush wins.
- Flush while in HOLD: skid is dropped.

## Test plan
- Reset release, ROM returns addr|0xA000 → IF/ID shows pc 0x0 at edge 2, then 0x4, 0x8 on consecutive edges with valid=1 and pc4 = pc+4.
- 1-cycle stop at the cycle when req_pc_q=0x8 → IF/ID holds 0x4 for two edges, then 0x8 (from skid), then 0xC. No duplicate or missing PC, and `irom_req`=0 during the stop.
- 3-cycle stop → skid filled once, `irom_addr` stable, sequence continues 0x8, 0xC after release.
- Flush with `redirect_pc`=0x100 → next edge: if_id_valid=0 and inst=0x0340_0000; following edge: pc 0x100; then 0x104. The stale response is never seen.
- Flush+stop in the same cycle while in HOLD → flush behaviour only; skid_valid=0; target 0x200 reaches IF/ID two edges later.
- Assert `cpu_rst` mid-stall with skid full → all outputs return immediately (asynchronously) to reset values; refetch begins at `RESET_PC` after release. Also check the PC wrap from 0xFFFF_FFFC to 0x0.
